// File: rtl/tt_mux_pkg.sv
// tt_mux_pkg: scheduler state encoding and pad bus widths/slices shared with the project wrappers and ow mux
package tt_mux_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DROP    = 3'd1,
      ISOLATE = 3'd2,
      HOLD    = 3'd3,
      RUN     = 3'd4
   } sched_state_e;

   // Input word driven into every wrapper: clk, rst_n, ui_in, uio_in
   localparam int IW_W          = 18;
   localparam int IW_CLK_BIT    = 0;
   localparam int IW_RST_N_BIT  = 1;
   localparam int IW_UI_LSB     = 2;
   localparam int IW_UI_W       = 8;
   localparam int IW_UIO_LSB    = 10;
   localparam int IW_UIO_W      = 8;

   // Output word returned by the selected wrapper: uo_out, uio_out, uio_oe
   localparam int OW_W          = 24;
   localparam int OW_UO_LSB     = 0;
   localparam int OW_UO_W       = 8;
   localparam int OW_UIO_LSB    = 8;
   localparam int OW_UIO_W      = 8;
   localparam int OW_OE_LSB     = 16;
   localparam int OW_OE_W       = 8;

endpackage

// File: rtl/tt_sched_timer.sv
// tt_sched_timer: loadable down-counter that parks at zero
//   clk, rst      clock, async active-high reset (count clears to 0)
//   load          load load_val this cycle (takes priority over counting)
//   load_val      value to load
//   zero          count is zero
module tt_sched_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst)
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);

   assign zero = cnt == '0;

endmodule

// File: rtl/tt_proj_sched.sv
// tt_proj_sched: sequences which project wrapper on the shared pad bus is live (ena, rst_n, ow mux select)
//   clk, rst     clock, async active-high reset
//   sel_valid    command valid; accepted with sel_ready at posedge
//   sel_ready    high in IDLE or RUN
//   sel_addr     target project index
//   sel_off      command disables all projects
//   sel_err      one-cycle pulse after an accepted out-of-range address
//   pad_rst_n    user reset from pads, passed through only in RUN
//   proj_ena     one-hot (or zero) wrapper enable
//   proj_rst_n   rst_n into the selected wrapper
//   out_sel      ow mux select, current project
//   out_valid    ow mux enable
//   busy         switch sequence in progress
module tt_proj_sched #(
   parameter int N_PROJ   = 16,
   parameter int ADDR_W   = 4,
   parameter int SETTLE   = 2,
   parameter int RST_HOLD = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel_valid,
   output logic              sel_ready,
   input  logic [ADDR_W-1:0] sel_addr,
   input  logic              sel_off,
   output logic              sel_err,
   input  logic              pad_rst_n,
   output logic [N_PROJ-1:0] proj_ena,
   output logic              proj_rst_n,
   output logic [ADDR_W-1:0] out_sel,
   output logic              out_valid,
   output logic              busy
);

   import tt_mux_pkg::*;

   localparam int TMAX = (SETTLE > RST_HOLD) ? SETTLE : RST_HOLD;
   localparam int TW   = $clog2(TMAX + 1);

   sched_state_e      state;
   logic [ADDR_W-1:0] target;
   logic              tgt_none;
   logic              run;
   logic              t_load;
   logic              t_zero;
   logic [TW-1:0]     t_val;
   logic [ADDR_W:0]   addr_ext;

   // Widened so the range check stays meaningful when N_PROJ fills the address space
   assign addr_ext   = {1'b0, sel_addr};
   assign sel_ready  = state == IDLE || state == RUN;
   assign proj_rst_n = run & pad_rst_n;

   // Timer reloads on entry to ISOLATE and on entry to HOLD
   always_comb begin
      t_load = state == DROP || (state == ISOLATE && t_zero && !tgt_none);
      t_val  = state == DROP ? TW'(SETTLE - 1) : TW'(RST_HOLD - 1);
   end

   tt_sched_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .load_val (t_val),
      .zero     (t_zero)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         target    <= '0;
         tgt_none  <= 1'b1;
         run       <= 1'b0;
         proj_ena  <= '0;
         out_sel   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sel_err   <= 1'b0;
      end else begin
         sel_err <= 1'b0;
         case (state)
            IDLE, RUN:
               if (sel_valid) begin
                  if (!sel_off && addr_ext >= (ADDR_W+1)'(N_PROJ))
                     sel_err <= 1'b1;
                  else begin
                     state     <= DROP;
                     target    <= sel_addr;
                     tgt_none  <= sel_off;
                     run       <= 1'b0;
                     proj_ena  <= '0;
                     out_valid <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
            DROP:
               state <= ISOLATE;
            ISOLATE:
               if (t_zero) begin
                  if (tgt_none) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     // New project comes up enabled but held in reset
                     state    <= HOLD;
                     proj_ena <= {{(N_PROJ-1){1'b0}}, 1'b1} << target;
                     out_sel  <= target;
                  end
               end
            HOLD:
               if (t_zero) begin
                  state     <= RUN;
                  run       <= 1'b1;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
               end
            default:
               state <= IDLE;
         endcase
      end

endmodule

// File: tb/tb_tt_proj_sched.sv
module tb_tt_proj_sched;

   localparam int SETTLE   = 2;
   localparam int RST_HOLD = 8;
   localparam int LAT_ON   = 1 + SETTLE + RST_HOLD;
   localparam int LAT_OFF  = 1 + SETTLE;

   typedef struct {
      logic [15:0] ena;
      logic [3:0]  sel;
      logic        chk_sel;
      logic        valid;
      int          lat;
      int          t0;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pad_rst_n = 1'b1;
   logic        sel_valid = 1'b0, sel_ready, sel_off = 1'b0, sel_err;
   logic [3:0]  sel_addr = '0, out_sel;
   logic [15:0] proj_ena;
   logic        proj_rst_n, out_valid, busy;

   logic        e_valid = 1'b0, e_ready, e_off = 1'b0, e_err;
   logic [3:0]  e_addr = '0, e_sel;
   logic [11:0] e_ena;
   logic        e_rst_n, e_ovalid, e_busy;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   tt_proj_sched #(.N_PROJ(16), .ADDR_W(4), .SETTLE(SETTLE), .RST_HOLD(RST_HOLD)) dut (
      .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_addr(sel_addr),
      .sel_off(sel_off), .sel_err(sel_err), .pad_rst_n(pad_rst_n), .proj_ena(proj_ena),
      .proj_rst_n(proj_rst_n), .out_sel(out_sel), .out_valid(out_valid), .busy(busy)
   );

   tt_proj_sched #(.N_PROJ(12), .ADDR_W(4), .SETTLE(SETTLE), .RST_HOLD(RST_HOLD)) dut_e (
      .clk(clk), .rst(rst), .sel_valid(e_valid), .sel_ready(e_ready), .sel_addr(e_addr),
      .sel_off(e_off), .sel_err(e_err), .pad_rst_n(pad_rst_n), .proj_ena(e_ena),
      .proj_rst_n(e_rst_n), .out_sel(e_sel), .out_valid(e_ovalid), .busy(e_busy)
   );

   always @(negedge clk)
      if (!rst) begin
         checks++;
         if ($countones(proj_ena) > 1 || (proj_ena != 16'h0 && proj_ena != (16'h1 << out_sel))) begin
            errors++;
            $display("FAIL onehot cyc=%0d ena=%h out_sel=%0d", cyc, proj_ena, out_sel);
         end
      end

   task automatic send(input logic [3:0] a, input logic off);
      exp_t e;
      int   g = 0;
      sel_addr = a; sel_off = off; sel_valid = 1'b1;
      while (!sel_ready && g < 64) begin @(negedge clk); g++; end
      @(negedge clk);
      sel_valid = 1'b0;
      e.ena = off ? 16'h0 : 16'h1 << a;
      e.sel = a;
      e.chk_sel = !off;
      e.valid = !off;
      e.lat = off ? LAT_OFF : LAT_ON;
      e.t0 = cyc;
      q.push_back(e);
   endtask

   task automatic drain(input string tag);
      exp_t e;
      int   g = 0;
      while (busy && g < 64) begin @(negedge clk); g++; end
      checks++;
      if (busy !== 1'b0 || q.size() == 0) begin
         errors++;
         $display("FAIL %s done busy=%b queued=%0d required busy=0 queued>0", tag, busy, q.size());
      end else begin
         e = q.pop_front();
         checks++;
         if ({proj_ena, out_valid, sel_ready, sel_err} !== {e.ena, e.valid, 2'b10}) begin
            errors++;
            $display("FAIL %s state ena=%h ov=%b rdy=%b err=%b required ena=%h ov=%b rdy=1 err=0",
                     tag, proj_ena, out_valid, sel_ready, sel_err, e.ena, e.valid);
         end
         checks++;
         if (cyc - e.t0 !== e.lat) begin
            errors++;
            $display("FAIL %s latency got=%0d required=%0d", tag, cyc - e.t0, e.lat);
         end
         checks++;
         if (proj_rst_n !== (e.valid & pad_rst_n)) begin
            errors++;
            $display("FAIL %s rst_n got=%b required=%b", tag, proj_rst_n, e.valid & pad_rst_n);
         end
         if (e.chk_sel) begin
            checks++;
            if (out_sel !== e.sel) begin
               errors++;
               $display("FAIL %s out_sel got=%0d required=%0d", tag, out_sel, e.sel);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({proj_ena, proj_rst_n, out_valid, sel_ready, busy, sel_err, out_sel} !== {16'h0, 5'b00100, 4'd0}) begin
         errors++;
         $display("FAIL reset ena=%h rst_n=%b ov=%b rdy=%b busy=%b err=%b sel=%0d required 0,0,0,1,0,0,0",
                  proj_ena, proj_rst_n, out_valid, sel_ready, busy, sel_err, out_sel);
      end
   endtask

   task automatic test_select3();
      send(4'd3, 1'b0);
      for (int k = 1; k <= LAT_ON; k++) begin
         @(negedge clk);
         checks++;
         if (k <= SETTLE) begin
            if (proj_ena !== 16'h0) begin
               errors++;
               $display("FAIL sel3 isolate edge=%0d ena=%h required 0000", k, proj_ena);
            end
         end else if (k < LAT_ON) begin
            if ({proj_ena, out_sel, proj_rst_n, out_valid} !== {16'h0008, 4'd3, 2'b00}) begin
               errors++;
               $display("FAIL sel3 hold edge=%0d ena=%h sel=%0d rst_n=%b ov=%b required 0008,3,0,0",
                        k, proj_ena, out_sel, proj_rst_n, out_valid);
            end
         end else if ({out_valid, proj_rst_n} !== 2'b11) begin
            errors++;
            $display("FAIL sel3 run edge=%0d ov=%b rst_n=%b required 1,1", k, out_valid, proj_rst_n);
         end
      end
      pad_rst_n = 1'b0;
      #1;
      checks++;
      if (proj_rst_n !== 1'b0) begin
         errors++;
         $display("FAIL sel3 pad_low rst_n=%b required 0", proj_rst_n);
      end
      pad_rst_n = 1'b1;
      #1;
      checks++;
      if (proj_rst_n !== 1'b1) begin
         errors++;
         $display("FAIL sel3 pad_high rst_n=%b required 1", proj_rst_n);
      end
      drain("sel3");
   endtask

   task automatic test_switch();
      int last3, first7, g = 0;
      last3 = cyc;
      checks++;
      if (proj_ena !== 16'h0008) begin
         errors++;
         $display("FAIL switch pre ena=%h required 0008", proj_ena);
      end
      send(4'd7, 1'b0);
      while (!proj_ena[7] && g < 40) begin
         checks++;
         if (proj_ena[3] !== 1'b0) begin
            errors++;
            $display("FAIL switch overlap cyc=%0d ena=%h required bit3=0", cyc, proj_ena);
         end
         @(negedge clk);
         g++;
      end
      first7 = cyc;
      checks++;
      if (first7 - last3 !== SETTLE + 2) begin
         errors++;
         $display("FAIL switch gap got=%0d required=%0d", first7 - last3, SETTLE + 2);
      end
      drain("switch7");
   endtask

   task automatic test_err();
      int g = 0;
      e_addr = 4'd5; e_valid = 1'b1;
      @(negedge clk);
      e_valid = 1'b0;
      while (!e_ovalid && g < 40) begin @(negedge clk); g++; end
      checks++;
      if ({e_ena, e_sel, e_ovalid, e_err} !== {12'h020, 4'd5, 2'b10}) begin
         errors++;
         $display("FAIL err_pre ena=%h sel=%0d ov=%b err=%b required 020,5,1,0", e_ena, e_sel, e_ovalid, e_err);
      end
      for (int a = 12; a <= 15; a += 3) begin
         e_addr = 4'(a); e_valid = 1'b1;
         @(negedge clk);
         e_valid = 1'b0;
         checks++;
         if ({e_err, e_ena, e_sel, e_ready, e_busy, e_ovalid} !== {1'b1, 12'h020, 4'd5, 3'b101}) begin
            errors++;
            $display("FAIL err_pulse addr=%0d err=%b ena=%h sel=%0d rdy=%b busy=%b ov=%b required 1,020,5,1,0,1",
                     a, e_err, e_ena, e_sel, e_ready, e_busy, e_ovalid);
         end
         @(negedge clk);
         checks++;
         if ({e_err, e_ena, e_busy} !== {1'b0, 12'h020, 1'b0}) begin
            errors++;
            $display("FAIL err_clear addr=%0d err=%b ena=%h busy=%b required 0,020,0", a, e_err, e_ena, e_busy);
         end
      end
   endtask

   task automatic test_off_reselect();
      int holds = 0, g = 0;
      send(4'd0, 1'b1);
      drain("off");
      send(4'd5, 1'b0);
      while (busy && g < 40) begin
         if (proj_ena === 16'h0020 && !out_valid && !proj_rst_n) holds++;
         @(negedge clk);
         g++;
      end
      checks++;
      if (holds !== RST_HOLD) begin
         errors++;
         $display("FAIL reselect hold_cycles got=%0d required=%0d", holds, RST_HOLD);
      end
      drain("reselect5");
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   g = 0;
      sel_addr = 4'd4; sel_off = 1'b0; sel_valid = 1'b1;
      @(negedge clk);
      e.ena = 16'h0010; e.sel = 4'd4; e.chk_sel = 1'b1; e.valid = 1'b1; e.lat = LAT_ON; e.t0 = cyc;
      q.push_back(e);
      sel_addr = 4'd6;
      while (!out_valid && g < 40) begin @(negedge clk); g++; end
      e = q.pop_front();
      checks++;
      if ({proj_ena, out_sel} !== {e.ena, e.sel} || cyc - e.t0 !== e.lat) begin
         errors++;
         $display("FAIL b2b first ena=%h sel=%0d lat=%0d required ena=%h sel=%0d lat=%0d",
                  proj_ena, out_sel, cyc - e.t0, e.ena, e.sel, e.lat);
      end
      @(negedge clk);
      sel_valid = 1'b0;
      checks++;
      if ({busy, out_valid, proj_ena} !== {2'b10, 16'h0}) begin
         errors++;
         $display("FAIL b2b retake busy=%b ov=%b ena=%h required 1,0,0000", busy, out_valid, proj_ena);
      end
      e.ena = 16'h0040; e.sel = 4'd6; e.t0 = cyc;
      q.push_back(e);
      drain("b2b6");
   endtask

   task automatic test_rst_mid();
      int a, g = 0;
      send(4'd9, 1'b0);
      a = cyc;
      while (cyc < a + SETTLE + 5 && g < 40) begin @(negedge clk); g++; end
      checks++;
      if (proj_ena !== 16'h0200 || proj_rst_n !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid hold ena=%h rst_n=%b required 0200,0", proj_ena, proj_rst_n);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({proj_ena, busy, out_valid, sel_ready, proj_rst_n} !== {16'h0, 4'b0010}) begin
         errors++;
         $display("FAIL rst_mid async ena=%h busy=%b ov=%b rdy=%b rst_n=%b required 0000,0,0,1,0",
                  proj_ena, busy, out_valid, sel_ready, proj_rst_n);
      end
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(4'd2, 1'b0);
      drain("after_rst");
   endtask

   initial begin
      test_reset();
      test_select3();
      test_switch();
      test_err();
      test_off_reselect();
      test_back_to_back();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
